// File: rtl/nn_loader_pkg.sv
// Shared types and header decoding for the neuron parameter loader.
// Header layout: [31:28] opcode, [27:24] layer, [23:16] neuron, [15:0] count.
package nn_loader_pkg;

  typedef enum logic [3:0] {
    OP_WEIGHT = 4'h1,
    OP_BIAS   = 4'h2,
    OP_END    = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    HDR    = 2'd0,
    WEIGHT = 2'd1,
    BIAS   = 2'd2
  } state_e;

  localparam int unsigned OP_MSB     = 32'd31;
  localparam int unsigned OP_LSB     = 32'd28;
  localparam int unsigned LAYER_MSB  = 32'd27;
  localparam int unsigned LAYER_LSB  = 32'd24;
  localparam int unsigned NEURON_MSB = 32'd23;
  localparam int unsigned NEURON_LSB = 32'd16;
  localparam int unsigned COUNT_MSB  = 32'd15;
  localparam int unsigned COUNT_LSB  = 32'd0;

  typedef struct packed {
    logic [3:0]  opcode;
    logic [3:0]  layer;
    logic [7:0]  neuron;
    logic [15:0] count;
  } hdr_t;

  function automatic hdr_t decode_hdr(input logic [31:0] word);
    hdr_t h;
    h.opcode = word[OP_MSB:OP_LSB];
    h.layer  = word[LAYER_MSB:LAYER_LSB];
    h.neuron = word[NEURON_MSB:NEURON_LSB];
    h.count  = word[COUNT_MSB:COUNT_LSB];
    return h;
  endfunction

endpackage

// File: rtl/nn_param_loader.sv
// Transmit side of the neuron weight/bias load bus: decodes a header/payload
// command stream into weight and bias strobes plus the target layer/neuron.
module nn_param_loader
  import nn_loader_pkg::*;
#(
  parameter int dataWidth   = 32'd16,
  parameter int layerWidth  = 32'd4,
  parameter int neuronWidth = 32'd8,
  parameter int cntWidth    = 32'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [31:0] mWeight,
  output logic        mWeightValid,
  output logic [31:0] mBias,
  output logic        mBiasValid,
  output logic [31:0] config_layer_num,
  output logic [31:0] config_neuron_num,
  output logic        config_done,
  output logic        busy,
  output logic        err
);

  localparam logic [cntWidth-1:0] CNT_ONE = {{(cntWidth-1){1'b0}}, 1'b1};

  state_e                 state_r;
  state_e                 state_n_s;
  logic [cntWidth-1:0]    cnt_r;
  logic [cntWidth-1:0]    cnt_n_s;
  logic [dataWidth-1:0]   weight_r;
  logic [dataWidth-1:0]   bias_r;
  logic                   weight_valid_r;
  logic                   bias_valid_r;
  logic [layerWidth-1:0]  cfg_layer_r;
  logic [neuronWidth-1:0] cfg_neuron_r;
  logic                   done_r;
  logic                   busy_r;
  logic                   err_r;

  hdr_t hdr_s;
  logic accept_s;
  logic cfg_load_s;
  logic weight_stb_s;
  logic bias_stb_s;
  logic done_stb_s;
  logic err_set_s;

  // Header fields are decoded on every word; only used while in HDR.
  assign hdr_s    = decode_hdr(s_data);
  assign s_ready  = ~rst;
  assign accept_s = s_valid & ~rst;

  // Next-state, counter and strobe decision for the current accepted word.
  always_comb begin
    state_n_s    = state_r;
    cnt_n_s      = cnt_r;
    cfg_load_s   = 1'b0;
    weight_stb_s = 1'b0;
    bias_stb_s   = 1'b0;
    done_stb_s   = 1'b0;
    err_set_s    = 1'b0;
    case (state_r)
      HDR: begin
        if (accept_s) begin
          case (hdr_s.opcode)
            OP_WEIGHT: begin
              if (hdr_s.count != 16'd0) begin
                state_n_s  = WEIGHT;
                cnt_n_s    = hdr_s.count[cntWidth-1:0] - CNT_ONE;
                cfg_load_s = 1'b1;
              end else begin
                err_set_s = 1'b1;
              end
            end
            OP_BIAS: begin
              state_n_s  = BIAS;
              cfg_load_s = 1'b1;
            end
            OP_END:  done_stb_s = 1'b1;
            default: err_set_s  = 1'b1;
          endcase
        end else begin
          state_n_s = HDR;
        end
      end
      WEIGHT: begin
        if (accept_s) begin
          weight_stb_s = 1'b1;
          // Counter holds at zero on the final word instead of wrapping.
          if (cnt_r == '0) begin
            state_n_s = HDR;
          end else begin
            cnt_n_s = cnt_r - CNT_ONE;
          end
        end else begin
          state_n_s = WEIGHT;
        end
      end
      BIAS: begin
        if (accept_s) begin
          bias_stb_s = 1'b1;
          state_n_s  = HDR;
        end else begin
          state_n_s = BIAS;
        end
      end
      default: begin
        state_n_s = HDR;
        cnt_n_s   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= HDR;
      cnt_r          <= '0;
      weight_r       <= '0;
      bias_r         <= '0;
      weight_valid_r <= 1'b0;
      bias_valid_r   <= 1'b0;
      cfg_layer_r    <= '0;
      cfg_neuron_r   <= '0;
      done_r         <= 1'b0;
      busy_r         <= 1'b0;
      err_r          <= 1'b0;
    end else begin
      state_r        <= state_n_s;
      cnt_r          <= cnt_n_s;
      weight_valid_r <= weight_stb_s;
      bias_valid_r   <= bias_stb_s;
      done_r         <= done_stb_s;
      busy_r         <= (state_n_s == WEIGHT) || (state_n_s == BIAS);
      err_r          <= err_r | err_set_s;
      if (weight_stb_s) weight_r <= s_data[dataWidth-1:0];
      if (bias_stb_s)   bias_r   <= s_data[dataWidth-1:0];
      if (cfg_load_s) begin
        cfg_layer_r  <= hdr_s.layer[layerWidth-1:0];
        cfg_neuron_r <= hdr_s.neuron[neuronWidth-1:0];
      end
    end
  end

  assign mWeight           = {{(32-dataWidth){1'b0}}, weight_r};
  assign mBias             = {{(32-dataWidth){1'b0}}, bias_r};
  assign mWeightValid      = weight_valid_r;
  assign mBiasValid        = bias_valid_r;
  assign config_layer_num  = {{(32-layerWidth){1'b0}}, cfg_layer_r};
  assign config_neuron_num = {{(32-neuronWidth){1'b0}}, cfg_neuron_r};
  assign config_done       = done_r;
  assign busy              = busy_r;
  assign err               = err_r;

endmodule

// File: tb/tb_nn_param_loader.sv
// Bench for nn_param_loader: word-level stream model builds the expected
// strobe sequence, a monitor collects what the DUT actually emits.
module tb_nn_param_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] s_data = 32'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] mWeight, mBias, config_layer_num, config_neuron_num;
  logic        mWeightValid, mBiasValid, config_done, busy, err;

  int checks = 0;
  int errors = 0;

  nn_param_loader dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mWeight(mWeight), .mWeightValid(mWeightValid), .mBias(mBias), .mBiasValid(mBiasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .config_done(config_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Entry: {is_bias, value, layer, neuron}
  logic [96:0] obs_q[$];
  logic [96:0] exp_q[$];
  int done_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (mWeightValid) obs_q.push_back({1'b0, mWeight, config_layer_num, config_neuron_num});
    if (mBiasValid)   obs_q.push_back({1'b1, mBias, config_layer_num, config_neuron_num});
    if (mWeightValid && mBiasValid) both_cnt++;
    if (config_done) done_cnt++;
  end

  // Stream-level reference model: interprets each accepted word in order.
  int          m_rem = 0;
  bit          m_bias = 1'b0;
  bit          m_err = 1'b0;
  int          m_done = 0;
  logic [31:0] m_layer = 32'd0;
  logic [31:0] m_neuron = 32'd0;

  task automatic model_reset();
    m_rem = 0; m_bias = 1'b0; m_err = 1'b0; m_layer = 32'd0; m_neuron = 32'd0;
  endtask

  task automatic model_word(input logic [31:0] w);
    int op;
    int cnt;
    if (m_rem > 0) begin
      exp_q.push_back({1'b0, w & 32'h0000FFFF, m_layer, m_neuron});
      m_rem--;
    end else if (m_bias) begin
      exp_q.push_back({1'b1, w & 32'h0000FFFF, m_layer, m_neuron});
      m_bias = 1'b0;
    end else begin
      op  = int'(w >> 28);
      cnt = int'(w & 32'h0000FFFF);
      if (op == 1 && cnt != 0) begin
        m_rem = cnt; m_layer = (w >> 24) & 32'hF; m_neuron = (w >> 16) & 32'hFF;
      end else if (op == 2) begin
        m_bias = 1'b1; m_layer = (w >> 24) & 32'hF; m_neuron = (w >> 16) & 32'hFF;
      end else if (op == 15) begin
        m_done++;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] w, input int gap);
    idle(gap);
    s_valid = 1'b1;
    s_data  = w;
    model_word(w);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h11050003;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", s_ready); end
    rst = 1'b0; s_valid = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if ({mWeight, mBias, config_layer_num, config_neuron_num} !== 128'd0 ||
        {mWeightValid, mBiasValid, config_done, busy, err} !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: w=%h b=%h l=%h n=%h flags=%b expected all zero",
               mWeight, mBias, config_layer_num, config_neuron_num,
               {mWeightValid, mBiasValid, config_done, busy, err});
    end
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_weight_burst(input int gap2);
    send(32'h11050003, 0);
    send(32'h0000AAAA, 0);
    idle(gap2);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL burst_busy: got %b expected 1", busy); end
    send(32'h0000BBBB, 0);
    send(32'h0000CCCC, 0);
    idle(2);
    checks++;
    if (obs_q.size() != 3 || exp_q.size() != 3) begin
      errors++; $display("FAIL burst_strobes: got %0d expected 3", obs_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL burst_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (config_layer_num !== 32'd1 || config_neuron_num !== 32'd5 || busy !== 1'b0) begin
      errors++; $display("FAIL burst_config: layer=%0d neuron=%0d busy=%b expected 1 5 0",
                         config_layer_num, config_neuron_num, busy);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bias();
    send(32'h20070000, 0);
    send(32'h12345678, 1);
    idle(2);
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL bias_strobes: got %0d expected 1", obs_q.size()); end
    checks++;
    if (obs_q.size() != 0 && obs_q[0] !== {1'b1, 32'h00005678, 32'd0, 32'd7}) begin
      errors++; $display("FAIL bias_value: got %h expected %h", obs_q[0], {1'b1, 32'h00005678, 32'd0, 32'd7});
    end
    checks++;
    if (exp_q.size() != 1) begin errors++; $display("FAIL bias_model: got %0d expected 1", exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_illegal();
    send(32'h30000000, 0);
    send(32'h10000000, 0);
    idle(2);
    checks++;
    if (err !== 1'b1 || busy !== 1'b0 || obs_q.size() != 0) begin
      errors++; $display("FAIL illegal_err: err=%b busy=%b strobes=%0d expected 1 0 0", err, busy, obs_q.size());
    end
    send(32'h12090002, 0);
    send(32'h00001111, 0);
    send(32'h00002222, 0);
    idle(2);
    checks++;
    if (obs_q.size() != 2 || err !== 1'b1) begin
      errors++; $display("FAIL illegal_recover: strobes=%0d err=%b expected 2 1", obs_q.size(), err);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL recover_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_end_and_abort();
    int d0;
    d0 = done_cnt;
    send(32'hF0000000, 0);
    idle(3);
    checks++;
    if (done_cnt - d0 != 1 || config_layer_num !== 32'd2 || config_neuron_num !== 32'd9) begin
      errors++; $display("FAIL end_done: pulses=%0d layer=%0d neuron=%0d expected 1 2 9",
                         done_cnt - d0, config_layer_num, config_neuron_num);
    end
    send(32'h13020005, 0);
    send(32'h00000101, 0);
    send(32'h00000202, 0);
    rst = 1'b1; s_valid = 1'b1; s_data = 32'h0000EEEE;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0; s_valid = 1'b0;
    model_reset();
    idle(3);
    checks++;
    if (obs_q.size() != 2 || busy !== 1'b0 || err !== 1'b0 || config_layer_num !== 32'd0) begin
      errors++; $display("FAIL abort_state: strobes=%0d busy=%b err=%b layer=%0d expected 2 0 0 0",
                         obs_q.size(), busy, err, config_layer_num);
    end
    send(32'h2401000F, 0);
    send(32'h0000BEEF, 0);
    idle(2);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL abort_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int kind, n;
    logic [31:0] w;
    for (int c = 0; c < 30; c++) begin
      kind = $urandom_range(0, 9);
      w = {4'h0, 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)), 16'd0};
      if (kind <= 4) begin
        n = $urandom_range(1, 6);
        send(w | 32'h10000000 | 32'(n), $urandom_range(0, 2));
        for (int k = 0; k < n; k++) send($urandom, ($urandom_range(0, 3) == 0) ? 1 : 0);
      end else if (kind <= 6) begin
        send(w | 32'h20000000, 0);
        send($urandom, $urandom_range(0, 1));
      end else if (kind == 7) begin
        send(32'hF0000000, 0);
      end else if (kind == 8) begin
        send(w | {4'($urandom_range(3, 14)), 28'd0}, 0);
      end else begin
        send(w | 32'h10000000, 0);
      end
    end
    idle(3);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++; $display("FAIL random_count: got %0d expected %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_word%0d: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    checks++;
    if (err !== m_err || done_cnt != m_done || both_cnt != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL random_flags: err=%b done=%0d both=%0d busy=%b expected %b %0d 0 0",
                         err, done_cnt, both_cnt, busy, m_err, m_done);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_weight_burst(0);
    test_weight_burst(2);
    test_bias();
    test_illegal();
    test_end_and_abort();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
